// File: rtl/ifid_hazard_ctrl_pkg.sv
// haz_pkg: shared state encoding and constants for the IF/ID hazard controller.
package haz_pkg;
  localparam logic RUN = 1'b0;
  localparam logic BUSY = 1'b1;
  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int MULDIV_LAT_MIN = 2;
endpackage

// File: rtl/ifid_hazard_ctrl_muldiv_busy_timer.sv
// muldiv_busy_timer: tracks the mult/div occupancy window after an op is accepted.
module muldiv_busy_timer
  import haz_pkg::*;
#(
  parameter int MULDIV_LAT = 4,
  parameter int CNT_W = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy
);
  logic r_st;
  logic [CNT_W-1:0] r_cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_st <= RUN;
      r_cnt <= '0;
    end else if (r_st == RUN) begin
      r_st <= start ? BUSY : RUN;
      r_cnt <= start ? CNT_W'(MULDIV_LAT - 1) : '0;
    end else begin
      r_st <= (r_cnt == CNT_W'(1)) ? RUN : BUSY;
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end
  assign busy = (r_st == BUSY);
endmodule

// File: rtl/ifid_hazard_ctrl.sv
// ifid_hazard_ctrl: IF/ID stall/flush/bubble sequencing for load-use, mult/div busy and branches.
// Optional HAZ_STALL_STATS_EN adds free-running stall and flush counters.
module ifid_hazard_ctrl
  import haz_pkg::*;
#(
  parameter int MULDIV_LAT = 4,
  parameter int CNT_W = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rt,
  input  logic        id_is_muldiv,
  input  logic        id_reads_hilo,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rt,
  input  logic        branch_taken,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        muldiv_busy,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);
  logic w_load_use, w_hilo_wait, w_stall, w_start;
  assign w_load_use = ex_mem_read & (ex_rt != REG_ZERO) &
                      ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));
  assign w_hilo_wait = muldiv_busy & (id_reads_hilo | id_is_muldiv);
  // A taken branch discards the ID instruction, so it overrides any stall.
  assign w_stall = (w_load_use | w_hilo_wait) & ~branch_taken;
  assign w_start = id_is_muldiv & ~w_stall & ~branch_taken;
  assign pc_en = ~w_stall;
  assign ifid_en = ~w_stall;
  assign ifid_flush = branch_taken;
  assign idex_bubble = w_stall | branch_taken;
  muldiv_busy_timer #(.MULDIV_LAT(MULDIV_LAT), .CNT_W(CNT_W)) u_timer (
    .clk(clk),
    .rst(rst),
    .start(w_start),
    .busy(muldiv_busy)
  );
`ifdef HAZ_STALL_STATS_EN
  logic [31:0] r_stall_cnt, r_flush_cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_stall_cnt <= r_stall_cnt + 32'(w_stall);
      r_flush_cnt <= r_flush_cnt + 32'(branch_taken);
    end
  end
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`else
  assign stall_cnt = 32'b0;
  assign flush_cnt = 32'b0;
`endif
endmodule
